dcache_line_bridge: RTL and testbench
=====================================

Name: dcache_line_bridge

Overview:
- Memory-side responder for the data cache's line bus: accepts one-cycle line read pulses (cpu_ren/cpu_raddr) and line write pulses (cpu_wen/cpu_waddr/cpu_wdata).
- Serves each request as four 32-bit word accesses to an asynchronous SRAM port.
- Returns refill lines as a one-cycle dev_rvalid pulse carrying 128-bit dev_rdata.
- Sits between the dcache and the off-chip data SRAM controller pins.

Parameters:
ACC_CYC, 2, cycles each SRAM word access is held (address/control stable); legal range 1..15
MEM_AW, 20, SRAM word-address width; mem_addr = line_addr[MEM_AW+1:2]

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
cpu_ren  input  4  line read request; any nonzero value = request (byte enables ignored)
cpu_raddr  input  32  read address; bits [3:0] ignored
cpu_wen  input  4  line write request; any nonzero value = request
cpu_waddr  input  32  write address; bits [3:0] ignored
cpu_wdata  input  128  write line; word i = bits [32i+31:32i]
dev_rrdy  output  1  bridge can accept a read request
dev_wrdy  output  1  bridge can accept a write request
dev_rvalid  output  1  one-cycle pulse, dev_rdata valid
dev_rdata  output  128  refill line; word i at bits [32i+31:32i]
mem_ce  output  1  SRAM chip enable, active-high
mem_we  output  1  SRAM write enable, active-high
mem_be  output  4  SRAM byte enables, always 4'b1111 when mem_ce=1, else 4'b0000
mem_addr  output  MEM_AW  SRAM word address
mem_wdata  output  32  SRAM write data
mem_rdata  input  32  SRAM read data (asynchronous; stable by end of the ACC_CYC-th cycle)

Behaviour:
- Reset: sync, active-high, wins over everything including an in-flight transfer. While rst=1 and on the first cycle after it: dev_rrdy=0, dev_wrdy=0, dev_rvalid=0, dev_rdata=0, mem_ce=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0. Counters clear; pending captures are dropped. From the second cycle after rst deasserts, the bridge is in IDLE with dev_rrdy=dev_wrdy=1.
- Outputs: all registered.
- State machine: IDLE, WRITE, READ, RESP.
- IDLE: dev_rrdy=dev_wrdy=1.
  - Sampling |cpu_wen capture the line base waddr[31:4] and the 128-bit data, then go to WRITE.
  - Sampling |cpu_ren capture raddr[31:4], then go to READ.
  - Both in the same cycle: capture both. WRITE runs first, then READ directly, with no return to IDLE. This guarantees dirty-writeback-before-refill ordering for the same line.
- Any state other than IDLE: dev_rrdy=dev_wrdy=0. Requests arriving there are ignored, as a protocol violation with no side effect.
- WRITE: for word k=0..3, hold mem_ce=1, mem_we=1, mem_addr={base,k}, mem_wdata=word k for exactly ACC_CYC consecutive cycles. Then k increments with no idle gap. After k=3 go to READ if a read is pending, else IDLE.
- READ: for word k=0..3, hold mem_ce=1, mem_we=0, mem_addr={base,k} for ACC_CYC cycles. mem_rdata is captured into dev_rdata word k on the clock edge ending the ACC_CYC-th cycle. After k=3 go to RESP.
- RESP: dev_rvalid=1 for exactly one cycle with the full line on dev_rdata. Next state is IDLE; dev_rrdy/dev_wrdy return to 1 the following cycle.
- dev_rdata: holds its value after RESP until the next READ overwrites it.
- Latency:
  - Read: cpu_ren sampled at edge E → dev_rvalid high in cycle E+4*ACC_CYC+1 (ACC_CYC=2: 9 cycles).
  - Write: occupies 4*ACC_CYC cycles after acceptance. No completion pulse; dev_wrdy re-rising marks completion.
- Counters: 2-bit word counter and 4-bit access-cycle counter. Both wrap/clear at every word and state boundary. No arithmetic beyond increment.
- Addresses: mem_addr = {line_addr[MEM_AW+1:4], k}. Upper address bits beyond MEM_AW+2 are dropped (no aliasing check).

Test Plan:
- Reset then single read: preload SRAM words 0x100..0x103 = 0x11111111,0x22222222,0x33333333,0x44444444; pulse cpu_ren=4'hF, cpu_raddr=0x00000400 (ACC_CYC=2) → dev_rvalid exactly one cycle, 9 cycles later, dev_rdata=0x44444444_33333333_22222222_11111111; dev_rrdy=0 throughout.
- Single write: cpu_wen=4'hF, cpu_waddr=0x0000040C, cpu_wdata=0xDDDD..._AAAAAAAA → SRAM 0x100..0x103 written in order, each mem_we held 2 cycles; dev_wrdy low 8 cycles, high on cycle 9; dev_rvalid never asserts.
- Simultaneous write+read to same line 0x400 → write of new data completes before the first read access; dev_rvalid returns the newly written line, 17 cycles after acceptance.
- Request while busy: pulse cpu_ren again mid-READ → ignored; exactly one dev_rvalid pulse; SRAM access trace unchanged.
- Reset mid-WRITE after word 1 → mem_ce=0 next cycle; words 2–3 not written; dev_rrdy/dev_wrdy=1 two cycles after rst release.
- ACC_CYC=1 read → dev_rvalid 5 cycles after cpu_ren sampled, with correct data.

Source files
------------

// File: rtl/dcache_line_bridge.sv
// dcache_line_bridge
// Memory-side responder for the data cache line bus. Each accepted line
// request is served as four 32-bit word accesses on an asynchronous SRAM
// port. Each word access holds its address and control for ACC_CYC cycles.
// Refill lines come back as a one-cycle dev_rvalid pulse. When a write and
// a read arrive together, the write runs first. This keeps a dirty writeback
// ahead of the refill for the same line.
//
// Parameters:
//   ACC_CYC   cycles each SRAM word access is held (1..15)
//   MEM_AW    SRAM word-address width
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cpu_ren/cpu_raddr   line read request (any nonzero enable), line address
//   cpu_wen/cpu_waddr   line write request (any nonzero enable), line address
//   cpu_wdata           128-bit write line, word i at [32i+31:32i]
//   dev_rrdy/dev_wrdy   bridge can accept a read / write request
//   dev_rvalid          one-cycle pulse, dev_rdata carries the refill line
//   dev_rdata           refill line, held until the next read overwrites it
//   mem_ce/mem_we/mem_be/mem_addr/mem_wdata   SRAM control, all registered
//   mem_rdata           SRAM read data (asynchronous)
module dcache_line_bridge #(
    parameter int ACC_CYC = 2,
    parameter int MEM_AW  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        cpu_ren,
    input  logic [31:0]       cpu_raddr,
    input  logic [3:0]        cpu_wen,
    input  logic [31:0]       cpu_waddr,
    input  logic [127:0]      cpu_wdata,
    output logic              dev_rrdy,
    output logic              dev_wrdy,
    output logic              dev_rvalid,
    output logic [127:0]      dev_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int BW = MEM_AW - 2;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    state_t          state, state_nx;
    logic [1:0]      word, word_nx;
    logic [3:0]      cnt, cnt_nx;
    logic [BW-1:0]   wbase, wbase_nx;
    logic [BW-1:0]   rbase, rbase_nx;
    logic [127:0]    wbuf, wbuf_nx;
    logic            rd_pend, rd_pend_nx;
    logic            started;

    logic            wreq;
    logic            rreq;
    logic            accept;
    logic            word_done;

    logic            rdy_d;
    logic            rvalid_d;
    logic            ce_d;
    logic            we_d;
    logic [3:0]      be_d;
    logic [MEM_AW-1:0] addr_d;
    logic [31:0]     wdata_d;

    // Offset bits and address bits above the SRAM range are dropped by design.
    logic            unused_addr_bits;
    assign unused_addr_bits = ^{cpu_raddr[31:MEM_AW+2], cpu_raddr[3:0],
                                cpu_waddr[31:MEM_AW+2], cpu_waddr[3:0]};

    assign wreq      = |cpu_wen;
    assign rreq      = |cpu_ren;
    // The registered ready flag is high only in IDLE after the reset recovery cycle.
    assign accept    = dev_wrdy;
    assign word_done = (cnt == 4'(ACC_CYC - 1));

    // State register: FSM state, counters and captured request fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            word    <= 2'd0;
            cnt     <= 4'd0;
            wbase   <= '0;
            rbase   <= '0;
            wbuf    <= '0;
            rd_pend <= 1'b0;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            word    <= word_nx;
            cnt     <= cnt_nx;
            wbase   <= wbase_nx;
            rbase   <= rbase_nx;
            wbuf    <= wbuf_nx;
            rd_pend <= rd_pend_nx;
            started <= 1'b1;
        end
    end

    // Next-state logic. Both counters clear at every state boundary.
    // The 2-bit word counter wraps 3->0 by itself when a write hands over to a read.
    always_comb begin
        state_nx   = state;
        word_nx    = 2'd0;
        cnt_nx     = 4'd0;
        wbase_nx   = wbase;
        rbase_nx   = rbase;
        wbuf_nx    = wbuf;
        rd_pend_nx = rd_pend;
        case (state)
            IDLE: begin
                if (accept && wreq) begin
                    wbase_nx = cpu_waddr[MEM_AW+1:4];
                    wbuf_nx  = cpu_wdata;
                    state_nx = WRITE;
                end
                if (accept && rreq) begin
                    rbase_nx   = cpu_raddr[MEM_AW+1:4];
                    rd_pend_nx = wreq;
                    if (!wreq) begin
                        state_nx = READ;
                    end
                end
            end
            WRITE, READ: begin
                if (word_done) begin
                    word_nx = word + 2'd1;
                    if (word == 2'd3) begin
                        if (state == WRITE) begin
                            state_nx   = rd_pend ? READ : IDLE;
                            rd_pend_nx = 1'b0;
                        end else begin
                            state_nx = RESP;
                        end
                    end
                end else begin
                    word_nx = word;
                    cnt_nx  = cnt + 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Output logic. It is computed from the next state so that the registered
    // outputs line up with the state they describe.
    always_comb begin
        rdy_d    = started && (state_nx == IDLE);
        rvalid_d = (state_nx == RESP);
        ce_d     = (state_nx == WRITE) || (state_nx == READ);
        we_d     = (state_nx == WRITE);
        be_d     = ce_d ? 4'hF : 4'h0;
        addr_d   = '0;
        wdata_d  = '0;
        if (state_nx == WRITE) begin
            addr_d  = {wbase_nx, word_nx};
            wdata_d = wbuf_nx[{word_nx, 5'd0} +: 32];
        end else if (state_nx == READ) begin
            addr_d  = {rbase_nx, word_nx};
        end
    end

    // Output registers. A read word is captured on the edge that ends its
    // last hold cycle, while the address for that word is still driven.
    always_ff @(posedge clk) begin
        if (rst) begin
            dev_rrdy   <= 1'b0;
            dev_wrdy   <= 1'b0;
            dev_rvalid <= 1'b0;
            dev_rdata  <= '0;
            mem_ce     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= 4'h0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            dev_rrdy   <= rdy_d;
            dev_wrdy   <= rdy_d;
            dev_rvalid <= rvalid_d;
            mem_ce     <= ce_d;
            mem_we     <= we_d;
            mem_be     <= be_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            if (state == READ && word_done) begin
                dev_rdata[{word, 5'd0} +: 32] <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dcache_line_bridge.sv
// Testbench for dcache_line_bridge.
// Instance u_dut uses ACC_CYC=2 and is backed by a behavioural SRAM.
// Instance u_dut_b uses ACC_CYC=1, and its SRAM returns a pattern derived
// from the address.
// Stimulus pushes expected refill lines and SRAM writes into queues. A
// negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache_line_bridge;

    logic         clk = 1'b0;
    logic         rst;
    always #5 clk = ~clk;

    logic [3:0]   cpu_ren, cpu_wen;
    logic [31:0]  cpu_raddr, cpu_waddr;
    logic [127:0] cpu_wdata;
    logic         dev_rrdy, dev_wrdy, dev_rvalid;
    logic [127:0] dev_rdata;
    logic         mem_ce, mem_we;
    logic [3:0]   mem_be;
    logic [19:0]  mem_addr;
    logic [31:0]  mem_wdata, mem_rdata;

    logic [3:0]   b_cpu_ren;
    logic [31:0]  b_cpu_raddr;
    logic         b_dev_rrdy, b_dev_wrdy, b_dev_rvalid;
    logic [127:0] b_dev_rdata;
    logic         b_mem_ce, b_mem_we;
    logic [3:0]   b_mem_be;
    logic [19:0]  b_mem_addr;
    logic [31:0]  b_mem_wdata, b_mem_rdata;

    dcache_line_bridge #(.ACC_CYC(2), .MEM_AW(20)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_ren(cpu_ren), .cpu_raddr(cpu_raddr),
        .cpu_wen(cpu_wen), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .dev_rrdy(dev_rrdy), .dev_wrdy(dev_wrdy),
        .dev_rvalid(dev_rvalid), .dev_rdata(dev_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dcache_line_bridge #(.ACC_CYC(1), .MEM_AW(20)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_ren(b_cpu_ren), .cpu_raddr(b_cpu_raddr),
        .cpu_wen(4'h0), .cpu_waddr(32'h0), .cpu_wdata(128'h0),
        .dev_rrdy(b_dev_rrdy), .dev_wrdy(b_dev_wrdy),
        .dev_rvalid(b_dev_rvalid), .dev_rdata(b_dev_rdata),
        .mem_ce(b_mem_ce), .mem_we(b_mem_we), .mem_be(b_mem_be),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] sram [0:1023];
    logic        preloaded = 1'b0;
    assign mem_rdata   = (mem_ce && !mem_we) ? sram[mem_addr[9:0]] : 32'hDEAD_BEEF;
    assign b_mem_rdata = {12'hA5C, b_mem_addr};

    typedef struct { logic [127:0] data; int cyc; } rd_exp_t;
    typedef struct { logic [19:0] addr; logic [31:0] data; } wr_exp_t;
    rd_exp_t rd_q[$];
    rd_exp_t rdb_q[$];
    wr_exp_t wr_q[$];
    rd_exp_t re_e;
    wr_exp_t we_e;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got event, required none", name);
    endtask

    task automatic pushWrite(input logic [31:0] waddr, input logic [127:0] data, input int nwords);
        wr_exp_t e;
        for (int k = 0; k < nwords; k++) begin
            e.addr = {waddr[21:4], 2'(k)};
            e.data = data[32*k +: 32];
            wr_q.push_back(e);
        end
    endtask

    task automatic pushRead(input logic [127:0] data, input int at_cyc);
        rd_exp_t e;
        e.data = data;
        e.cyc  = at_cyc;
        rd_q.push_back(e);
    endtask

    // Drive one request on the cycle before an edge, then clear it. On return
    // the bench sits at the negedge of the first cycle after acceptance.
    // n is the cycle count before the accepting edge.
    task automatic applyStimulus(input logic [3:0] ren, input logic [31:0] raddr,
                                 input logic [3:0] wen, input logic [31:0] waddr,
                                 input logic [127:0] wdata, output int n);
        @(negedge clk);
        cpu_ren   = ren;
        cpu_raddr = raddr;
        cpu_wen   = wen;
        cpu_waddr = waddr;
        cpu_wdata = wdata;
        n = cyc;
        @(negedge clk);
        cpu_ren   = 4'h0;
        cpu_wen   = 4'h0;
        cpu_raddr = 32'h0;
        cpu_waddr = 32'h0;
        cpu_wdata = 128'h0;
    endtask

    task automatic checkBusy(input int nbusy, input string name);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < nbusy; i++) begin
            if (dev_rrdy || dev_wrdy) ok = 1'b0;
            @(negedge clk);
        end
        checkOutput({name, "_busy"}, 128'(ok), 128'(1));
        checkOutput({name, "_ready"}, {dev_rrdy, dev_wrdy}, 128'(2'b11));
    endtask

    task automatic waitIdle(input string name);
        int i;
        i = 0;
        while (!(dev_rrdy && dev_wrdy) && i < 100) begin
            @(negedge clk);
            i++;
        end
        if (i >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: got not ready, required ready within 100 cycles", name);
        end
    endtask

    // Monitor: behavioural SRAM writes, the write-trace scoreboard and the
    // refill scoreboards for both instances.
    int          run_len = 0;
    logic        run_active = 1'b0;
    logic [19:0] run_addr = '0;
    always @(negedge clk) begin
        if (!preloaded) begin
            for (int k = 0; k < 4; k++) begin
                sram[10'h100 + 10'(k)] = 32'h1111_1111 * (k + 1);
                sram[10'h200 + 10'(k)] = 32'h9000_0000 + 32'(k);
            end
            preloaded = 1'b1;
        end
        if (run_active && !(mem_ce && mem_we && mem_addr == run_addr)) begin
            checkOutput("write_hold_len", 128'(run_len), 128'(2));
            run_active = 1'b0;
        end
        if (mem_ce && mem_we) begin
            sram[mem_addr[9:0]] = mem_wdata;
            if (run_active) begin
                run_len++;
            end else begin
                run_active = 1'b1;
                run_addr   = mem_addr;
                run_len    = 1;
                if (wr_q.size() == 0) begin
                    failNow("unexpected_write");
                end else begin
                    we_e = wr_q.pop_front();
                    checkOutput("write_word", {mem_be, mem_addr, mem_wdata}, {4'hF, we_e.addr, we_e.data});
                end
            end
        end
        if (dev_rvalid) begin
            if (rd_q.size() == 0) begin
                failNow("unexpected_rvalid");
            end else begin
                re_e = rd_q.pop_front();
                checkOutput("rdata", dev_rdata, re_e.data);
                checkOutput("rvalid_cycle", 128'(cyc), 128'(re_e.cyc));
            end
        end
        if (b_dev_rvalid) begin
            if (rdb_q.size() == 0) begin
                failNow("unexpected_rvalid_b");
            end else begin
                re_e = rdb_q.pop_front();
                checkOutput("rdata_b", b_dev_rdata, re_e.data);
                checkOutput("rvalid_cycle_b", 128'(cyc), 128'(re_e.cyc));
            end
        end
    end

    initial begin
        int n;
        int i;
        rd_exp_t eb;
        rst = 1'b1;
        cpu_ren = 4'h0; cpu_wen = 4'h0;
        cpu_raddr = 32'h0; cpu_waddr = 32'h0; cpu_wdata = 128'h0;
        b_cpu_ren = 4'h0; b_cpu_raddr = 32'h0;

        // Reset state and recovery timing
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", {dev_rrdy, dev_wrdy, dev_rvalid, mem_ce, mem_we, mem_be, mem_addr, mem_wdata}, 128'h0);
        checkOutput("reset_rdata", dev_rdata, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_first_cycle", {dev_rrdy, dev_wrdy, dev_rvalid, mem_ce}, 128'h0);
        @(negedge clk);
        checkOutput("reset_ready", {dev_rrdy, dev_wrdy}, 128'(2'b11));

        // Single read of preloaded line 0x400
        $display("[TB] single read");
        applyStimulus(4'hF, 32'h0000_0400, 4'h0, 32'h0, 128'h0, n);
        pushRead(128'h44444444_33333333_22222222_11111111, n + 9);
        checkBusy(9, "read1");

        // Single write; offset bits of the address are ignored
        $display("[TB] single write");
        pushWrite(32'h0000_0400, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 4);
        applyStimulus(4'h0, 32'h0, 4'hF, 32'h0000_040C, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, n);
        checkBusy(8, "write1");

        // Simultaneous write and read of the same line: the refill sees the new data
        $display("[TB] write+read same line");
        pushWrite(32'h0000_0400, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 4);
        applyStimulus(4'h3, 32'h0000_0400, 4'h1, 32'h0000_0400, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, n);
        pushRead(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, n + 17);
        checkBusy(17, "wr_rd");

        // Second read request while busy is ignored
        $display("[TB] request while busy");
        applyStimulus(4'hF, 32'h0000_0400, 4'h0, 32'h0, 128'h0, n);
        pushRead(128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, n + 9);
        @(negedge clk);
        cpu_ren = 4'hF;
        cpu_raddr = 32'h0000_0800;
        @(negedge clk);
        cpu_ren = 4'h0;
        cpu_raddr = 32'h0;
        waitIdle("busy");
        repeat (3) @(negedge clk);

        // Reset in the middle of a write, right after word 1 completes
        $display("[TB] reset mid-write");
        pushWrite(32'h0000_0800, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, 2);
        applyStimulus(4'h0, 32'h0, 4'hF, 32'h0000_0800, 128'hF3F3F3F3_F2F2F2F2_F1F1F1F1_F0F0F0F0, n);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_outputs", {mem_ce, mem_we, dev_rrdy, dev_wrdy}, 128'h0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_first", {dev_rrdy, dev_wrdy, mem_ce}, 128'h0);
        @(negedge clk);
        checkOutput("rst_mid_ready", {dev_rrdy, dev_wrdy}, 128'(2'b11));

        // Line 0x800 holds the two new words and the two untouched preloaded words
        $display("[TB] read after aborted write");
        applyStimulus(4'h8, 32'h0000_0800, 4'h0, 32'h0, 128'h0, n);
        pushRead(128'h90000003_90000002_F1F1F1F1_F0F0F0F0, n + 9);
        waitIdle("post_abort");

        // ACC_CYC=1 instance: refill 5 cycles after acceptance
        $display("[TB] ACC_CYC=1 read");
        @(negedge clk);
        b_cpu_ren = 4'hF;
        b_cpu_raddr = 32'h0000_1230;
        eb.data = 128'hA5C0048F_A5C0048E_A5C0048D_A5C0048C;
        eb.cyc = cyc + 5;
        rdb_q.push_back(eb);
        @(negedge clk);
        b_cpu_ren = 4'h0;
        b_cpu_raddr = 32'h0;

        i = 0;
        while ((rd_q.size() != 0 || rdb_q.size() != 0 || wr_q.size() != 0) && i < 50) begin
            @(negedge clk);
            i++;
        end
        repeat (3) @(negedge clk);
        checkOutput("queues_drained", 128'(rd_q.size() + rdb_q.size() + wr_q.size()), 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
